// File: rtl/axis_pacer.sv
// -----------------------------------------------------------------------------
// axis_pacer
//
// Purpose:
//   Generates the 'pause' input of the AXI-stream throttle on the NIC egress
//   path. It snoops the throttle's output handshake to follow packet
//   boundaries and to count beats per time window. Two pause sources are
//   combined:
//     - a software pause request, honoured only between packets. If a packet
//       is open, the FSM drains the packet first.
//     - a per-window beat budget, enforced immediately, even mid-packet.
//   All outputs are registered. The deciding event (budget-reaching beat,
//   tlast beat in DRAIN) is the last beat passed; pause is high the next cycle.
//
// Parameters:
//   WW  width of cfg_window and of the window cycle counter
//   BW  width of cfg_beats and of the beats-used counter
//
// Ports:
//   clk                in   clock
//   reset              in   synchronous reset, active-high
//   sw_pause           in   software pause request (level)
//   cfg_window[WW]     in   window length in cycles, 0 behaves as 1
//   cfg_beats[BW]      in   max beats per window, 0 disables the budget
//   mon_tvalid         in   snooped throttle output tvalid
//   mon_tready         in   snooped throttle output tready
//   mon_tlast          in   snooped throttle output tlast
//   pause              out  pause request to the throttle (registered)
//   sw_paused          out  FSM is in PAUSED
//   budget_hold        out  budget for the current window is exhausted
//   in_packet          out  a packet is open (beat seen, tlast not yet seen)
//   stat_beats[32]         out  (AXIS_PACER_STATS_EN only) handshake count
//   stat_pause_cycles[32]  out  (AXIS_PACER_STATS_EN only) cycles with pause=1
//
// Optional feature:
//   Define AXIS_PACER_STATS_EN to add the two free-running statistics
//   counters. They wrap modulo 2^32 and clear only on reset. Without the
//   macro, the ports and their logic are absent. All other behaviour is the
//   same in both builds.
// -----------------------------------------------------------------------------
module axis_pacer #(
  parameter int WW = 24,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sw_pause,
  input  logic [WW-1:0] cfg_window,
  input  logic [BW-1:0] cfg_beats,
  input  logic          mon_tvalid,
  input  logic          mon_tready,
  input  logic          mon_tlast,
  output logic          pause,
  output logic          sw_paused,
  output logic          budget_hold,
  output logic          in_packet
`ifdef AXIS_PACER_STATS_EN
  ,
  output logic [31:0]   stat_beats,
  output logic [31:0]   stat_pause_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] win_cnt;
  logic [WW-1:0] win_cnt_next;
  logic [WW-1:0] win_last;
  logic          win_wrap;
  logic [BW-1:0] beats_used;
  logic [BW-1:0] beats_used_next;
  logic          hs;
  logic          in_packet_next;
  logic          budget_next;

  assign hs = mon_tvalid & mon_tready;

  // Packet tracking. A beat with tlast closes the packet. Any other beat
  // opens it or keeps it open.
  always_comb begin
    in_packet_next = in_packet;
    if (hs) begin
      in_packet_next = ~mon_tlast;
    end else begin
      in_packet_next = in_packet;
    end
  end

  // Software-pause FSM. Moving to PAUSED waits until no packet is open,
  // including a packet whose first beat passes in this same cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (sw_pause) begin
          if (in_packet_next) begin
            state_next = DRAIN;
          end else begin
            state_next = PAUSED;
          end
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (!sw_pause) begin
          state_next = RUN;
        end else if (!in_packet_next) begin
          state_next = PAUSED;
        end else begin
          state_next = DRAIN;
        end
      end
      PAUSED: begin
        if (!sw_pause) begin
          state_next = RUN;
        end else begin
          state_next = PAUSED;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Window counter. The counter wraps after max(cfg_window,1) cycles. The
  // compare is >= so that shrinking cfg_window below the running count
  // forces a wrap right away instead of running to all-ones.
  always_comb begin
    win_last     = {WW{1'b0}};
    win_wrap     = 1'b0;
    win_cnt_next = win_cnt;
    if (cfg_window == {WW{1'b0}}) begin
      win_last = {WW{1'b0}};
    end else begin
      win_last = cfg_window - {{(WW-1){1'b0}}, 1'b1};
    end
    win_wrap = (win_cnt >= win_last);
    if (win_wrap) begin
      win_cnt_next = {WW{1'b0}};
    end else begin
      win_cnt_next = win_cnt + {{(WW-1){1'b0}}, 1'b1};
    end
  end

  // Beat budget. A beat in the wrap cycle belongs to the new window. The
  // count saturates, so a huge window can never wrap the count back under
  // the budget.
  always_comb begin
    beats_used_next = beats_used;
    if (win_wrap) begin
      beats_used_next = {{(BW-1){1'b0}}, hs};
    end else if (hs && (beats_used != {BW{1'b1}})) begin
      beats_used_next = beats_used + {{(BW-1){1'b0}}, 1'b1};
    end else begin
      beats_used_next = beats_used;
    end
    budget_next = (cfg_beats != {BW{1'b0}}) && (beats_used_next >= cfg_beats);
  end

  // State, counters and registered outputs. Outputs are computed from next
  // state, so pause rises in the cycle after the deciding beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      win_cnt     <= {WW{1'b0}};
      beats_used  <= {BW{1'b0}};
      in_packet   <= 1'b0;
      pause       <= 1'b0;
      sw_paused   <= 1'b0;
      budget_hold <= 1'b0;
    end else begin
      state       <= state_next;
      win_cnt     <= win_cnt_next;
      beats_used  <= beats_used_next;
      in_packet   <= in_packet_next;
      pause       <= (state_next == PAUSED) | budget_next;
      sw_paused   <= (state_next == PAUSED);
      budget_hold <= budget_next;
    end
  end

`ifdef AXIS_PACER_STATS_EN
  // Free-running statistics. They count handshakes and cycles where the
  // registered pause is high, wrap naturally, and clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_beats        <= 32'd0;
      stat_pause_cycles <= 32'd0;
    end else begin
      stat_beats        <= stat_beats + {31'd0, hs};
      stat_pause_cycles <= stat_pause_cycles + {31'd0, pause};
    end
  end
`else
  // This build has no statistics counters.
`endif

endmodule

// File: tb/tb_axis_pacer.sv
// -----------------------------------------------------------------------------
// tb_axis_pacer
//
// Directed bench for axis_pacer. The throttle is modelled by driving
// mon_tready low whenever the pacer's registered pause is high. Expected
// values are hand-derived from the pacer's behaviour. Inputs change 1 time
// unit after the rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_axis_pacer;

  localparam int WW = 24;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_pause;
  logic [WW-1:0] cfg_window;
  logic [BW-1:0] cfg_beats;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          pause;
  logic          sw_paused;
  logic          budget_hold;
  logic          in_packet;
`ifdef AXIS_PACER_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_pause_cycles;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic hs_last;

  axis_pacer #(.WW(WW), .BW(BW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_pause    (sw_pause),
    .cfg_window  (cfg_window),
    .cfg_beats   (cfg_beats),
    .mon_tvalid  (mon_tvalid),
    .mon_tready  (mon_tready),
    .mon_tlast   (mon_tlast),
    .pause       (pause),
    .sw_paused   (sw_paused),
    .budget_hold (budget_hold),
    .in_packet   (in_packet)
`ifdef AXIS_PACER_STATS_EN
    ,
    .stat_beats        (stat_beats),
    .stat_pause_cycles (stat_pause_cycles)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Guards against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances one clock. Records whether a handshake happened in the cycle
  // that just ended.
  task automatic cyc();
    hs_last = mon_tvalid & mon_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    sw_pause   = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Sends an n-beat packet through an unpaused throttle. sw_pause rises
  // with beat sw_on and falls with beat sw_off (0 = never). Pause must stay
  // low for every beat.
  task automatic send_pkt(input int n, input int sw_on, input int sw_off, input string tag);
    for (int k = 1; k <= n; k++) begin
      if (k == sw_on)  sw_pause = 1'b1;
      if (k == sw_off) sw_pause = 1'b0;
      mon_tvalid = 1'b1;
      mon_tlast  = (k == n);
      mon_tready = ~pause;
      check({tag, "_pass"}, {31'd0, pause}, 32'd0);
      cyc();
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    reset      = 1'b1;
    sw_pause   = 1'b0;
    cfg_window = 24'd100;
    cfg_beats  = 16'd10;
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;

    // Reset state
    reset_dut();
    check("rst_pause",       {31'd0, pause},       32'd0);
    check("rst_sw_paused",   {31'd0, sw_paused},   32'd0);
    check("rst_budget_hold", {31'd0, budget_hold}, 32'd0);
    check("rst_in_packet",   {31'd0, in_packet},   32'd0);

    // Budget test: 10 beats per 100-cycle window. Pause covers cycles 10..99.
    cfg_window = 24'd100;
    cfg_beats  = 16'd10;
    reset_dut();
    for (int w = 0; w < 3; w++) begin
      hs_cnt = 0;
      for (int c = 0; c < 100; c++) begin
        mon_tvalid = 1'b1;
        mon_tlast  = 1'b1;
        mon_tready = ~pause;
        check("budget_pause", {31'd0, pause}, (c >= 10) ? 32'd1 : 32'd0);
        if (c == 50) check("budget_hold_mid", {31'd0, budget_hold}, 32'd1);
        cyc();
        if (hs_last) hs_cnt++;
      end
      check("budget_hs_per_window", hs_cnt, 32'd10);
    end
`ifdef AXIS_PACER_STATS_EN
    check("stat_beats",        stat_beats,        32'd30);
    check("stat_pause_cycles", stat_pause_cycles, 32'd270);
`endif
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;

    // Drain: sw_pause rises during beat 3 of an 8-beat packet
    cfg_beats = 16'd0;
    reset_dut();
    send_pkt(8, 3, 0, "drain");
    check("drain_pause_after_tlast", {31'd0, pause},     32'd1);
    check("drain_sw_paused",         {31'd0, sw_paused}, 32'd1);
    check("drain_in_packet",         {31'd0, in_packet}, 32'd0);
    check("drain_budget_hold",       {31'd0, budget_hold}, 32'd0);
    // The next packet waits while paused.
    mon_tvalid = 1'b1;
    mon_tready = ~pause;
    cyc();
    check("drain_blocked_hs", {31'd0, hs_last}, 32'd0);
    check("drain_hold_pause", {31'd0, pause},   32'd1);
    sw_pause   = 1'b0;
    mon_tready = ~pause;
    cyc();
    check("drain_release_pause", {31'd0, pause},     32'd0);
    check("drain_release_swp",   {31'd0, sw_paused}, 32'd0);
    mon_tvalid = 1'b0;

    // Boundary start: sw_pause rises together with the first beat
    reset_dut();
    sw_pause   = 1'b1;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
    cyc();
    check("bstart_in_drain_swp", {31'd0, sw_paused}, 32'd0);
    check("bstart_in_packet",    {31'd0, in_packet}, 32'd1);
    send_pkt(3, 0, 0, "bstart");
    check("bstart_pause_after_tlast", {31'd0, pause},     32'd1);
    check("bstart_sw_paused",         {31'd0, sw_paused}, 32'd1);
    sw_pause = 1'b0;
    cyc();

    // Abort: sw_pause drops while in DRAIN
    reset_dut();
    send_pkt(8, 2, 5, "abort");
    check("abort_pause",     {31'd0, pause},     32'd0);
    check("abort_sw_paused", {31'd0, sw_paused}, 32'd0);
    check("abort_in_packet", {31'd0, in_packet}, 32'd0);
    cyc();
    check("abort_idle_pause", {31'd0, pause}, 32'd0);

    // Budget reached on the last beat of a 4-beat packet
    cfg_window = 24'd1000;
    cfg_beats  = 16'd4;
    reset_dut();
    send_pkt(4, 0, 0, "lastbeat");
    check("lastbeat_pause",       {31'd0, pause},       32'd1);
    check("lastbeat_budget_hold", {31'd0, budget_hold}, 32'd1);
    check("lastbeat_sw_paused",   {31'd0, sw_paused},   32'd0);

    // Lowering cfg_beats mid-packet, then reset mid-packet
    reset_dut();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
    cyc();
    cyc();
    mon_tvalid = 1'b0;
    check("midpkt_in_packet", {31'd0, in_packet}, 32'd1);
    check("midpkt_pause",     {31'd0, pause},     32'd0);
    cfg_beats = 16'd2;
    cyc();
    check("lower_beats_pause", {31'd0, pause},       32'd1);
    check("lower_beats_hold",  {31'd0, budget_hold}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_pause",     {31'd0, pause},       32'd0);
    check("midrst_in_packet", {31'd0, in_packet},   32'd0);
    check("midrst_hold",      {31'd0, budget_hold}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
